mcycle_muldiv: RTL and testbench

- Iterative multi-cycle multiply/divide unit in the Execute stage of the pipelined ARM core.
- Accepts a Start pulse held by the instruction in E and produces a two-word result.
- Drives Busy, which the hazard unit consumes as MCycleBusy to stall F/D/E and flush M.
- Covers MUL/UMULL/SMULL-style multiplies and signed/unsigned divide.

---
 rtl/mcycle_muldiv_pkg.sv | 22 ++
 rtl/mcycle_signfix.sv | 13 +
 rtl/mcycle_muldiv.sv | 196 +++++++++++++++++++
 tb/tb_mcycle_muldiv.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/mcycle_muldiv_pkg.sv
// Shared encodings for the multi-cycle multiply/divide unit.
// Operation codes, FSM states and the iteration-counter width helper.
package mcycle_muldiv_pkg;

  typedef enum logic [1:0] {
    MC_SMUL = 2'b00,
    MC_UMUL = 2'b01,
    MC_SDIV = 2'b10,
    MC_UDIV = 2'b11
  } mc_op_e;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    COMPUTING = 2'b01,
    DONE      = 2'b10
  } mc_state_e;

  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/mcycle_signfix.sv
// Conditional two's-complement negate; purely combinational, zero latency.
// Used for operand magnitudes and for the final result sign correction.
module mcycle_signfix #(
  parameter int W = 32
) (
  input  logic [W-1:0] i_val,
  input  logic         i_neg,
  output logic [W-1:0] o_val
);

  assign o_val = i_neg ? ((~i_val) + {{(W-1){1'b0}}, 1'b1}) : i_val;

endmodule

// File: rtl/mcycle_muldiv.sv
// Iterative radix-2 multiply/divide: Busy for WIDTH+1 cycles from Start, results in DONE.
// Busy stalls the pipeline; DONE lasts one cycle and ignores Start so the same instruction cannot restart.
module mcycle_muldiv
  import mcycle_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             Start,
  input  logic [1:0]       MCycleOp,
  input  logic [WIDTH-1:0] Operand1,
  input  logic [WIDTH-1:0] Operand2,
  output logic [WIDTH-1:0] Result1,
  output logic [WIDTH-1:0] Result2,
  output logic             Busy
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  mc_state_e        r_state;
  mc_state_e        w_state_nxt;
  logic             w_busy;
  logic             w_start;
  logic             w_last;

  mc_op_e           r_op;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_mag2;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_sign1;
  logic             r_sign2;
  logic             r_dz;
  logic [WIDTH-1:0] r_op1;
  logic [WIDTH-1:0] r_res1;
  logic [WIDTH-1:0] r_res2;

  logic             w_in_signed;
  logic [WIDTH-1:0] w_mag1;
  logic [WIDTH-1:0] w_mag2;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_mul_hi_in;
  logic [WIDTH-1:0] w_mhi;
  logic [WIDTH-1:0] w_mlo;
  logic [WIDTH:0]   w_rsh;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_dhi;
  logic [WIDTH-1:0] w_dlo;
  logic [WIDTH-1:0] w_hi_nxt;
  logic [WIDTH-1:0] w_lo_nxt;

  logic               w_neg_p;
  logic               w_neg_q;
  logic               w_neg_r;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quot;
  logic [WIDTH-1:0]   w_rem;
  logic [WIDTH-1:0]   w_fin1;
  logic [WIDTH-1:0]   w_fin2;

  // Signed ops are the even encodings (SMUL, SDIV).
  assign w_in_signed = ~MCycleOp[0];

  mcycle_signfix #(.W(WIDTH)) u_abs1 (
    .i_val (Operand1),
    .i_neg (w_in_signed & Operand1[WIDTH-1]),
    .o_val (w_mag1)
  );

  mcycle_signfix #(.W(WIDTH)) u_abs2 (
    .i_val (Operand2),
    .i_neg (w_in_signed & Operand2[WIDTH-1]),
    .o_val (w_mag2)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  assign w_last = (r_cnt == CNT_LAST);

  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    case (r_state)
      IDLE: begin
        if (Start) begin
          w_state_nxt = COMPUTING;
          w_busy      = 1'b1;
        end
      end
      COMPUTING: begin
        w_busy = 1'b1;
        if (w_last) w_state_nxt = DONE;
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_start = (r_state == IDLE) & Start;
  assign Busy    = ~RESET & w_busy;

  // Multiply: {hi,lo} holds partial product and remaining multiplier bits.
  assign w_sum       = {1'b0, r_hi} + {1'b0, r_mag2};
  assign w_mul_hi_in = r_lo[0] ? w_sum : {1'b0, r_hi};
  assign w_mhi       = w_mul_hi_in[WIDTH:1];
  assign w_mlo       = {w_mul_hi_in[0], r_lo[WIDTH-1:1]};

  // Divide: hi is the partial remainder, lo shifts dividend out and quotient in.
  assign w_rsh  = {r_hi, r_lo[WIDTH-1]};
  assign w_diff = w_rsh - {1'b0, r_mag2};
  assign w_dhi  = w_diff[WIDTH] ? w_rsh[WIDTH-1:0] : w_diff[WIDTH-1:0];
  assign w_dlo  = {r_lo[WIDTH-2:0], ~w_diff[WIDTH]};

  assign w_hi_nxt = r_op[1] ? w_dhi : w_mhi;
  assign w_lo_nxt = r_op[1] ? w_dlo : w_mlo;

  assign w_neg_p = (r_op == MC_SMUL) & (r_sign1 ^ r_sign2);
  assign w_neg_q = (r_op == MC_SDIV) & (r_sign1 ^ r_sign2);
  assign w_neg_r = (r_op == MC_SDIV) & r_sign1;

  mcycle_signfix #(.W(2*WIDTH)) u_fix_prod (
    .i_val ({w_hi_nxt, w_lo_nxt}),
    .i_neg (w_neg_p),
    .o_val (w_prod)
  );

  mcycle_signfix #(.W(WIDTH)) u_fix_quot (
    .i_val (w_lo_nxt),
    .i_neg (w_neg_q),
    .o_val (w_quot)
  );

  mcycle_signfix #(.W(WIDTH)) u_fix_rem (
    .i_val (w_hi_nxt),
    .i_neg (w_neg_r),
    .o_val (w_rem)
  );

  always_comb begin
    w_fin1 = w_prod[WIDTH-1:0];
    w_fin2 = w_prod[2*WIDTH-1:WIDTH];
    if (r_op[1]) begin
      if (r_dz) begin
        w_fin1 = {WIDTH{1'b1}};
        w_fin2 = r_op1;
      end else begin
        w_fin1 = w_quot;
        w_fin2 = w_rem;
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_op    <= MC_SMUL;
      r_cnt   <= '0;
      r_mag2  <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_sign1 <= 1'b0;
      r_sign2 <= 1'b0;
      r_dz    <= 1'b0;
      r_op1   <= '0;
      r_res1  <= '0;
      r_res2  <= '0;
    end else if (w_start) begin
      r_op    <= mc_op_e'(MCycleOp);
      r_cnt   <= '0;
      r_mag2  <= w_mag2;
      r_hi    <= '0;
      r_lo    <= w_mag1;
      r_sign1 <= w_in_signed & Operand1[WIDTH-1];
      r_sign2 <= w_in_signed & Operand2[WIDTH-1];
      r_dz    <= (Operand2 == '0);
      r_op1   <= Operand1;
    end else if (r_state == COMPUTING) begin
      r_hi  <= w_hi_nxt;
      r_lo  <= w_lo_nxt;
      r_cnt <= r_cnt + CNT_W'(1);
      if (w_last) begin
        r_res1 <= w_fin1;
        r_res2 <= w_fin2;
      end
    end
  end

  assign Result1 = r_res1;
  assign Result2 = r_res2;

endmodule

// File: tb/tb_mcycle_muldiv.sv
// Directed bench for mcycle_muldiv: arithmetic model plus per-cycle Busy/result compare.
module tb_mcycle_muldiv;

  localparam int W = 32;

  logic         CLK = 1'b0;
  logic         RESET;
  logic         Start;
  logic [1:0]   MCycleOp;
  logic [W-1:0] Operand1;
  logic [W-1:0] Operand2;
  logic [W-1:0] Result1;
  logic [W-1:0] Result2;
  logic         Busy;

  always #5 CLK = ~CLK;

  mcycle_muldiv #(.WIDTH(W)) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .Start    (Start),
    .MCycleOp (MCycleOp),
    .Operand1 (Operand1),
    .Operand2 (Operand2),
    .Result1  (Result1),
    .Result2  (Result2),
    .Busy     (Busy)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Returns {Result2, Result1} from plain arithmetic on the operands.
  function automatic logic [63:0] model_res(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    logic signed [63:0] sa64;
    logic signed [63:0] sb64;
    int sa;
    int sb;
    logic [31:0] q;
    logic [31:0] r;
    case (op)
      2'b00: begin
        sa64 = {{32{a[31]}}, a};
        sb64 = {{32{b[31]}}, b};
        return sa64 * sb64;
      end
      2'b01: return {32'h0, a} * {32'h0, b};
      default: begin
        if (b == 32'h0) return {a, 32'hFFFFFFFF};
        if (op == 2'b11) return {a % b, a / b};
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
        sa = a;
        sb = b;
        q = 32'(sa / sb);
        r = 32'(sa % sb);
        return {r, q};
      end
    endcase
  endfunction

  int          m_mode = 0;
  int          m_left = 0;
  logic [31:0] m_r1 = '0;
  logic [31:0] m_r2 = '0;
  logic [63:0] m_pend = '0;

  // Timing model: Start accepted when idle, W compute cycles, then one done cycle.
  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      m_mode = 0;
      m_left = 0;
      m_r1   = '0;
      m_r2   = '0;
    end else begin
      case (m_mode)
        0: if (Start) begin
          m_pend = model_res(MCycleOp, Operand1, Operand2);
          m_left = W;
          m_mode = 1;
        end
        1: begin
          m_left--;
          if (m_left == 0) begin
            m_mode = 2;
            m_r1   = m_pend[31:0];
            m_r2   = m_pend[63:32];
          end
        end
        default: m_mode = 0;
      endcase
    end
  end

  always @(negedge CLK) begin
    logic exp_busy;
    exp_busy = !RESET && (m_mode == 1 || (m_mode == 0 && Start === 1'b1));
    chk("cyc_busy", 64'(Busy), 64'(exp_busy));
    chk("cyc_result1", 64'(Result1), 64'(m_r1));
    chk("cyc_result2", 64'(Result2), 64'(m_r2));
  end

  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] e1, input logic [31:0] e2,
                        input bit hold);
    int n;
    @(posedge CLK);
    #1;
    Start    = 1'b1;
    MCycleOp = op;
    Operand1 = a;
    Operand2 = b;
    n = 0;
    @(negedge CLK);
    while (Busy === 1'b1 && n < 100) begin
      n++;
      if (n == 6) begin
        #1;
        Operand1 = ~a;
        Operand2 = b ^ 32'h00005A5A;
        MCycleOp = ~op;
      end
      @(negedge CLK);
    end
    chk({name, " busy_cycles"}, 64'(n), 64'(33));
    chk({name, " r1"}, 64'(Result1), 64'(e1));
    chk({name, " r2"}, 64'(Result2), 64'(e2));
    if (!hold) begin
      #1;
      Start = 1'b0;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET    = 1'b1;
    Start    = 1'b0;
    MCycleOp = 2'b00;
    Operand1 = '0;
    Operand2 = '0;

    chk("pin_umul", model_res(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF), 64'hFFFFFFFE_00000001);
    chk("pin_smul", model_res(2'b00, 32'hFFFFFFFD, 32'h5), 64'hFFFFFFFF_FFFFFFF1);
    chk("pin_sdiv", model_res(2'b10, 32'hFFFFFFF9, 32'h2), 64'hFFFFFFFF_FFFFFFFD);
    chk("pin_sovf", model_res(2'b10, 32'h80000000, 32'hFFFFFFFF), 64'h00000000_80000000);

    repeat (3) @(negedge CLK);
    chk("rst_busy", 64'(Busy), 64'(0));
    chk("rst_r1", 64'(Result1), 64'(0));
    chk("rst_r2", 64'(Result2), 64'(0));
    #2;
    RESET = 1'b0;

    run_op("umul_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 1'b0);
    run_op("smul_neg", 2'b00, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFF1, 32'hFFFFFFFF, 1'b0);
    run_op("sdiv_neg", 2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0);
    run_op("udiv", 2'b11, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    run_op("udiv_zero", 2'b11, 32'h12345678, 32'h0, 32'hFFFFFFFF, 32'h12345678, 1'b0);
    run_op("sdiv_zero", 2'b10, 32'hFFFFFFF9, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFF9, 1'b0);
    run_op("sdiv_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0, 1'b0);
    run_op("b2b_a", 2'b00, 32'd7, 32'hFFFFFFFA, 32'hFFFFFFD6, 32'hFFFFFFFF, 1'b1);
    run_op("b2b_b", 2'b10, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000001, 1'b0);

    @(posedge CLK);
    #1;
    Start    = 1'b1;
    MCycleOp = 2'b01;
    Operand1 = 32'hDEADBEEF;
    Operand2 = 32'h00001234;
    repeat (11) @(posedge CLK);
    #3;
    RESET = 1'b1;
    #1;
    chk("arst_busy", 64'(Busy), 64'(0));
    chk("arst_r1", 64'(Result1), 64'(0));
    chk("arst_r2", 64'(Result2), 64'(0));
    Start = 1'b0;
    @(negedge CLK);
    #2;
    RESET = 1'b0;

    run_op("after_rst", 2'b01, 32'd3, 32'd4, 32'd12, 32'd0, 1'b0);

    repeat (3) @(posedge CLK);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
